// File: rtl/id_hazard_forward_unit_pkg.sv
// Shared forwarding-select encodings and the register-match helper
// used by the ID-stage hazard and forwarding logic.
package id_hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_REG      = 2'b00;
    localparam logic [1:0] FWD_EXE_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU  = 2'b10;
    localparam logic [1:0] FWD_MEM_LOAD = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A later-stage write to a live (non-zero) register that the ID source names.
    function automatic logic reg_hit(input logic wr, input logic [4:0] dest, input logic [4:0] src);
        return wr && (dest != REG_ZERO) && (dest == src);
    endfunction

endpackage

// File: rtl/id_hazard_forward_unit_fwd_select.sv
// Purpose: picks the operand bypass source for one ID source register.
// Latency: combinational.
// Backpressure: none; pure decode of EXE and shadow MEM write info.
module id_hazard_forward_unit_fwd_select
    import id_hazard_forward_unit_pkg::*;
(
    input  logic [4:0] src,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] edestReg,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic [4:0] mdestReg,
    output logic [1:0] sel
);

    // EXE is checked first: it holds the youngest value of the register.
    always_comb begin
        sel = FWD_REG;
        if (reg_hit(ewreg && !em2reg, edestReg, src)) begin
            sel = FWD_EXE_ALU;
        end else if (reg_hit(mwreg && !mm2reg, mdestReg, src)) begin
            sel = FWD_MEM_ALU;
        end else if (reg_hit(mwreg && mm2reg, mdestReg, src)) begin
            sel = FWD_MEM_LOAD;
        end
    end

endmodule

// File: rtl/id_hazard_forward_unit.sv
// Purpose: ID-stage forwarding selects, load-use stall and event counters.
// Latency: selects/stall combinational; shadow MEM stage and counters 1 cycle.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EXE for one cycle.
module id_hazard_forward_unit
    import id_hazard_forward_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             usesRs,
    input  logic             usesRt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       edestReg,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             stall,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] fwdCount
);

    logic       mwreg;
    logic       mm2reg;
    logic [4:0] mdestReg;
    logic       fwd_event;

    // EXE never stalls, so the shadow MEM copy advances every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mwreg    <= 1'b0;
            mm2reg   <= 1'b0;
            mdestReg <= REG_ZERO;
        end else begin
            mwreg    <= ewreg;
            mm2reg   <= em2reg;
            mdestReg <= edestReg;
        end
    end

    id_hazard_forward_unit_fwd_select u_fwd_a (
        .src      (rs),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .edestReg (edestReg),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mdestReg (mdestReg),
        .sel      (fwda)
    );

    id_hazard_forward_unit_fwd_select u_fwd_b (
        .src      (rt),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .edestReg (edestReg),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mdestReg (mdestReg),
        .sel      (fwdb)
    );

    assign stall = (usesRs && reg_hit(ewreg && em2reg, edestReg, rs)) ||
                   (usesRt && reg_hit(ewreg && em2reg, edestReg, rt));

    assign fwd_event = ((fwda != FWD_REG) || (fwdb != FWD_REG)) && !stall;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            stallCount <= '0;
            fwdCount   <= '0;
        end else begin
            if (stall && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_W'(1);
            end
            if (fwd_event && (fwdCount != '1)) begin
                fwdCount <= fwdCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Directed checks of forwarding selects, load-use stall and saturating counters.
module tb_id_hazard_forward_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        usesRs;
    logic        usesRt;
    logic        ewreg;
    logic        em2reg;
    logic [4:0]  edestReg;

    logic [1:0]  fwda;
    logic [1:0]  fwdb;
    logic        stall;
    logic [15:0] stallCount;
    logic [15:0] fwdCount;

    logic [1:0]  fwda2;
    logic [1:0]  fwdb2;
    logic        stall2;
    logic [1:0]  stallCount2;
    logic [1:0]  fwdCount2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    id_hazard_forward_unit #(.CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .rs         (rs),
        .rt         (rt),
        .usesRs     (usesRs),
        .usesRt     (usesRt),
        .ewreg      (ewreg),
        .em2reg     (em2reg),
        .edestReg   (edestReg),
        .fwda       (fwda),
        .fwdb       (fwdb),
        .stall      (stall),
        .stallCount (stallCount),
        .fwdCount   (fwdCount)
    );

    id_hazard_forward_unit #(.CNT_W(2)) dut_sat (
        .clock      (clock),
        .reset      (reset),
        .rs         (rs),
        .rt         (rt),
        .usesRs     (usesRs),
        .usesRt     (usesRt),
        .ewreg      (ewreg),
        .em2reg     (em2reg),
        .edestReg   (edestReg),
        .fwda       (fwda2),
        .fwdb       (fwdb2),
        .stall      (stall2),
        .stallCount (stallCount2),
        .fwdCount   (fwdCount2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                         input logic w, input logic l, input logic [4:0] d);
        rs = a; rt = b; usesRs = ua; usesRt = ub;
        ewreg = w; em2reg = l; edestReg = d;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);

        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_val("rst_stall", 32'(stall), 32'd0);
            check_val("rst_stallcnt", 32'(stallCount), 32'd0);
            check_val("rst_fwdcnt", 32'(fwdCount), 32'd0);
            check_val("rst_fwda", 32'(fwda), 32'd0);
        end
        reset = 1'b0;
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5);
        check_val("post_rst_fwda", 32'(fwda), 32'd1);
        check_val("post_rst_fwdb", 32'(fwdb), 32'd0);
        cycle();
        check_val("fwdcnt_1", 32'(fwdCount), 32'd1);

        // ALU chain: EXE then shadow MEM
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8);
        check_val("chain_exe_fwda", 32'(fwda), 32'd1);
        cycle();
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        check_val("chain_mem_fwda", 32'(fwda), 32'd2);
        cycle();
        check_val("chain_fwdcnt", 32'(fwdCount), 32'd3);

        // Load-use on rt, then forward from shadow load
        drive(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9);
        check_val("lu_stall", 32'(stall), 32'd1);
        check_val("lu_fwdb", 32'(fwdb), 32'd0);
        cycle();
        check_val("lu_stallcnt", 32'(stallCount), 32'd1);
        check_val("lu_fwdcnt_nostep", 32'(fwdCount), 32'd3);
        drive(5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        check_val("lu_next_stall", 32'(stall), 32'd0);
        check_val("lu_next_fwdb", 32'(fwdb), 32'd3);
        cycle();
        check_val("lu_next_stallcnt", 32'(stallCount), 32'd1);
        check_val("lu_next_fwdcnt", 32'(fwdCount), 32'd4);

        // Priority: EXE beats MEM on same register
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
        check_val("pri_setup_fwda", 32'(fwda), 32'd0);
        cycle();
        drive(5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        check_val("pri_fwda", 32'(fwda), 32'd1);
        check_val("pri_fwdb", 32'(fwdb), 32'd1);
        cycle();
        drive(5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        check_val("mem_fwda", 32'(fwda), 32'd2);
        check_val("mem_fwdb", 32'(fwdb), 32'd2);
        cycle();
        check_val("pri_fwdcnt", 32'(fwdCount), 32'd6);

        // Register zero never stalls or forwards
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0);
        check_val("zero_stall", 32'(stall), 32'd0);
        check_val("zero_fwda", 32'(fwda), 32'd0);
        cycle();
        check_val("zero_stallcnt", 32'(stallCount), 32'd1);
        check_val("zero_fwdcnt", 32'(fwdCount), 32'd6);
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        check_val("zero_mem_fwda", 32'(fwda), 32'd0);

        // Mid-stream reset clears shadow stage and counters
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
        cycle();
        reset = 1'b1;
        cycle();
        check_val("mid_rst_stallcnt", 32'(stallCount), 32'd0);
        check_val("mid_rst_fwdcnt", 32'(fwdCount), 32'd0);
        reset = 1'b0;
        drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        check_val("mid_rst_shadow_fwda", 32'(fwda), 32'd0);
        cycle();

        // Saturation: load-use held five cycles
        drive(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check_val($sformatf("sat_cnt2_%0d", i), 32'(stallCount2), (i < 3) ? 32'(i) : 32'd3);
            check_val($sformatf("sat_cnt16_%0d", i), 32'(stallCount), 32'(i));
        end

        // Reset wins over a same-cycle increment
        reset = 1'b1;
        cycle();
        check_val("rst_pri_stallcnt", 32'(stallCount), 32'd0);
        check_val("rst_pri_stallcnt2", 32'(stallCount2), 32'd0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_hazard_forward_unit.md
Name: id_hazard_forward_unit

Overview:
- Consumer side of the ID/EXE interface: takes the EXE-stage control/destination outputs of the ID/EXE pipeline register and decides, for the instruction currently in ID, operand forwarding selects and load-use stalls.
- Keeps an internal shadow MEM-stage copy of the EXE-stage write info, so no EXE/MEM wiring is needed for hazard decisions.
- Also keeps saturating stall and forward event counters for performance debug.

Parameters:
- CNT_W, 16, width of each event counter.

Ports:
- clock  input  1  rising-edge clock; same name as every pipeline register.
- reset  input  1  synchronous, active-high reset.
- rs  input  5  source register A of the ID instruction.
- rt  input  5  source register B of the ID instruction.
- usesRs  input  1  ID instruction reads rs.
- usesRt  input  1  ID instruction reads rt.
- ewreg  input  1  EXE instruction writes the register file (ID/EXE output).
- em2reg  input  1  EXE instruction is a load (ID/EXE output).
- edestReg  input  5  EXE destination register (ID/EXE output).
- fwda  output  2  qa mux select: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data.
- fwdb  output  2  qb mux select, same encoding as fwda.
- stall  output  1  load-use hazard. Holds PC and IF/ID, and forces wreg=0 and wmem=0 into ID/EXE.
- stallCount  output  CNT_W  number of cycles with stall=1, saturating.
- fwdCount  output  CNT_W  number of cycles with any non-zero fwda/fwdb and stall=0, saturating.

Behaviour:
Shadow MEM stage:
- Registers mwreg, mm2reg and mdestReg load ewreg, em2reg and edestReg on every posedge.
- There is no enable, because EXE never stalls; stalls only insert bubbles in front of EXE.
- Reset clears all three to 0.

Stall (combinational):
- stall = ewreg & em2reg & (edestReg!=0) & ((usesRs & edestReg==rs) | (usesRt & edestReg==rt)).

fwda (combinational, priority order):
- 01 if ewreg & !em2reg & edestReg!=0 & edestReg==rs.
- Else 10 if mwreg & !mm2reg & mdestReg!=0 & mdestReg==rs.
- Else 11 if mwreg & mm2reg & mdestReg!=0 & mdestReg==rs.
- Else 00.

fwdb:
- Identical to fwda, using rt.
- usesRs and usesRt gate only stall, not fwd. An unused operand may show a non-zero select, which is harmless.

Boundary conditions:
- Register 0 is never forwarded and never causes a stall.
- When EXE and MEM match the same register, EXE wins because it holds the youngest value.
- During stall, fwda/fwdb are still computed by the rules above; the ID instruction is not consumed that cycle.
- A load-use stall lasts exactly 1 cycle under correct bubble insertion. Next cycle ewreg=0, and the load is in the shadow MEM stage, so fwd=11.

Counters:
- Both increment on the posedge where their condition holds.
- Both saturate at 2^CNT_W-1, with no wrap.
- Reset clears both to 0.
- Reset has priority over an increment in the same cycle.

Reset:
- After reset, with all inputs 0: fwda=fwdb=00, stall=0, counters=0.
- Reset asserted mid-stream clears the shadow stage, so forwarding from pre-reset MEM contents is impossible on the first cycle after reset.

Latency:
- Decisions are combinational, same cycle as inputs.
- Shadow stage: 1 cycle.
- Counters reflect events 1 cycle later.

Decomposition:
- Shared package holds:
  - FWD_REG=2'b00, FWD_EXE_ALU=2'b01, FWD_MEM_ALU=2'b10, FWD_MEM_LOAD=2'b11.
  - REG_ZERO=5'd0.
- One natural sub-module, fwd_select, instantiated twice (for rs and for rt). Inputs: source register, E/M write info. Output: 2-bit select.
- Counters stay inline.

Test Plan:
- Reset held 2 cycles with ewreg=1, edestReg=5 -> stall=0 and counters=0 during reset. After release, fwda=01 when rs=5, usesRs=1, em2reg=0.
- ALU chain: cycle0 ewreg=1, em2reg=0, edestReg=8. Cycle1 ewreg=0, rs=8 -> cycle0 fwda=01 (if rs=8), cycle1 fwda=10, fwdCount increments.
- Load-use: ewreg=1, em2reg=1, edestReg=9, rt=9, usesRt=1 -> stall=1 that cycle. Next cycle ewreg=0 -> stall=0, fwdb=11, stallCount=1.
- Priority: mdestReg=4 (ALU) in shadow, edestReg=4 (ALU) in EXE, rs=rt=4 -> fwda=fwdb=01.
- Zero register: ewreg=1, em2reg=1, edestReg=0, rs=0, usesRs=1 -> stall=0, fwda=00, counters unchanged.
- Saturation with CNT_W=2: hold the load-use condition for 5 cycles -> stallCount reads 1, 2, 3, 3, 3.
